mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares the single MemoryController port between three requesters: CPU (rd/wr), PPU (rd) and
//  ROM loader (wr). Also owns SDRAM auto-refresh scheduling. Sits between the NES core/loader
//  and MemoryController. Issues at most one command at a time and returns data with a 1-cycle ack.
// PARAMETERS
//  REFRESH_INTERVAL  780  clk cycles between refresh credits (7.8us at 100MHz)
//  REFRESH_MAX       7    saturation value of the pending-refresh credit counter
//  REFRESH_URGENT    4    credits at/above which refresh preempts all requesters
// PORTS
//  clk         in   1   main logic clock (single clock domain)
//  resetn      in   1   asynchronous, active-low reset
//  cpu_req     in   1   CPU request; held until cpu_ack
//  cpu_we      in   1   1=write, 0=read; stable while cpu_req
//  cpu_addr    in   22  CPU byte address
//  cpu_wdata   in   8   CPU write data
//  cpu_ack     out  1   1-cycle pulse: op complete
//  cpu_rdata   out  8   read data; valid in the cpu_ack cycle, held until the next CPU read ack
//  ppu_req     in   1   PPU read request; held until ppu_ack
//  ppu_addr    in   22  PPU byte address
//  ppu_ack     out  1   1-cycle completion pulse
//  ppu_rdata   out  8   read data; valid in the ppu_ack cycle, held afterwards
//  ldr_req     in   1   loader write request; held until ldr_ack
//  ldr_addr    in   22  loader byte address
//  ldr_wdata   in   8   loader write data
//  ldr_ack     out  1   1-cycle completion pulse
//  mc_read_a   out  1   1-cycle command pulse to MemoryController (CPU reads)
//  mc_read_b   out  1   1-cycle command pulse (PPU reads)
//  mc_write    out  1   1-cycle command pulse (writes)
//  mc_refresh  out  1   1-cycle command pulse (auto-refresh)
//  mc_addr     out  22  command address, registered
//  mc_din      out  8   command write data, registered
//  mc_dout_a   in   8   MemoryController read buffer a
//  mc_dout_b   in   8   MemoryController read buffer b
//  mc_busy     in   1   MemoryController busy; high during SDRAM init after reset
//  refresh_cnt out  3   pending refresh credits (debug)
// BEHAVIOUR
//  Reset (resetn=0, async): state=IDLE. All acks, mc_* pulses, mc_addr, mc_din, rdata and
//   refresh_cnt are 0. The RR pointer is set to favour PPU. The refresh timer is cleared.
//  Refresh timer: counts 0..REFRESH_INTERVAL-1. On wrap, refresh_cnt+1 (saturates at REFRESH_MAX).
//   A credit is consumed when the mc_refresh pulse issues. Wrap and consume in the same cycle:
//   the count is unchanged.
//  FSM IDLE -> ISSUE -> WAIT -> IDLE.
//  - IDLE: if mc_busy=0 and any source is eligible, pick a winner and register owner, addr and data.
//    Go to ISSUE.
//    Priority: refresh if refresh_cnt>=REFRESH_URGENT; else CPU/PPU round-robin (loser of the
//    last CPU/PPU contest wins a tie); else loader; else refresh if refresh_cnt>0.
//  - ISSUE (1 cycle): assert exactly one mc_* pulse per owner. Use mc_read_a for CPU read,
//    mc_read_b for PPU, mc_write for CPU write or loader, mc_refresh for refresh. Go to WAIT.
//  - WAIT: remain while mc_busy=1. On the first cycle after ISSUE, mc_busy is ignored (the
//    controller raises it the cycle after the command). When mc_busy=0: pulse the owner's ack;
//    for reads drive rdata from mc_dout_a (CPU) or mc_dout_b (PPU). Go to IDLE.
//    A refresh owner generates no ack.
//  Latency: min 3 cycles from IDLE grant to ack plus the controller busy time (~7 cycles/read).
//  A new grant is possible in the cycle after an ack. Back-to-back from the same requester is fine.
//  A req sampled in the ack cycle is ignored; the requester must deassert or re-present the req after
//   the ack (req still high the next cycle = new request).
//  Req dropped before ack: op still completes, ack still pulses (requester ignores it).
//  mc_busy high out of reset (SDRAM init): nothing issues; refresh credits still accumulate.
//  Addresses and data pass through unmodified (22-bit address space, 8-bit data).
// STRUCTURE
//  Shared package: FSM state encoding and owner encoding (OWN_CPU_RD/OWN_CPU_WR/OWN_PPU/OWN_LDR/
//  OWN_REF), default refresh constants.
//  Sub-module refresh_timer: interval counter plus saturating credit counter
//  (inputs consume; outputs refresh_cnt).
// TESTING
//  1 Reset with mc_busy=1 for 500 cycles, cpu_req=1 -> no mc_* pulse until mc_busy=0,
//    then mc_read_a then cpu_ack.
//  2 cpu_req(read 0x000010) and ppu_req(0x200000) in the same cycle from reset -> PPU served first,
//    then CPU. Repeat -> CPU first.
//  3 CPU write 0x380005=0xA5 then read 0x380005 with the model echoing -> mc_write, mc_din=0xA5;
//    cpu_rdata=0xA5 on ack.
//  4 Hold ldr_req with CPU/PPU requesting continuously -> loader starves only while they
//    request; acked within 1 op after they idle.
//  5 REFRESH_INTERVAL=16, no traffic -> one mc_refresh per 16 cycles. Saturate (mc_busy=1,
//    200 cycles) -> refresh_cnt=7, then drains; at >=4 refresh preempts pending CPU.
//  6 Assert resetn=0 in WAIT -> all outputs 0 asynchronously; after release, FSM is IDLE
//    and no stale ack appears.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared definitions for the memory arbiter: FSM state and command-owner
//   encodings, bus widths and default SDRAM refresh scheduling constants.
package mem_arbiter_pkg;

    localparam int unsigned ADDR_W = 22;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 3;

    // 7.8us between refresh credits at 100MHz
    localparam int unsigned REFRESH_INTERVAL_DEF = 780;
    localparam int unsigned REFRESH_MAX_DEF      = 7;
    localparam int unsigned REFRESH_URGENT_DEF   = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    typedef enum logic [2:0] {
        OWN_CPU_RD,
        OWN_CPU_WR,
        OWN_PPU,
        OWN_LDR,
        OWN_REF
    } owner_t;

endpackage

// File: rtl/mem_arbiter_refresh_timer.sv
// mem_arbiter_refresh_timer
//   Interval counter that earns one SDRAM refresh credit every INTERVAL
//   cycles, plus a saturating credit counter drained by issued refreshes.
// Ports
//   clk            main clock
//   resetn         asynchronous active-low reset
//   i_consume      a refresh command is issuing this cycle (uses one credit)
//   o_refresh_cnt  pending refresh credits
module mem_arbiter_refresh_timer
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned INTERVAL = REFRESH_INTERVAL_DEF,
    parameter int unsigned MAX      = REFRESH_MAX_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_consume,
    output logic [CNT_W-1:0] o_refresh_cnt
);

    localparam int unsigned      TW   = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam logic [TW-1:0]    LAST = TW'(INTERVAL - 1);
    localparam logic [CNT_W-1:0] SAT  = CNT_W'(MAX);

    logic [TW-1:0]    r_timer;
    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap        = (r_timer == LAST);
    assign o_refresh_cnt = r_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_timer <= '0;
            r_cnt   <= '0;
        end else begin
            r_timer <= w_wrap ? '0 : r_timer + TW'(1);
            // Earn and spend in the same cycle cancel out, even when saturated.
            if (w_wrap && !i_consume) begin
                if (r_cnt != SAT) r_cnt <= r_cnt + CNT_W'(1);
            end else if (!w_wrap && i_consume && r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one MemoryController command port between CPU (rd/wr), PPU (rd)
//   and ROM loader (wr), and schedules SDRAM auto-refresh. One command is in
//   flight at a time; completion is signalled by a 1-cycle ack.
// Ports
//   cpu_*      CPU request/ack, address, write data, read data
//   ppu_*      PPU read request/ack, address, read data
//   ldr_*      loader write request/ack, address, write data
//   mc_*       command pulses, registered address/data, read buffers, busy
//   refresh_cnt pending refresh credits (debug)
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned REFRESH_INTERVAL = REFRESH_INTERVAL_DEF,
    parameter int unsigned REFRESH_MAX      = REFRESH_MAX_DEF,
    parameter int unsigned REFRESH_URGENT   = REFRESH_URGENT_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ppu_req,
    input  logic [ADDR_W-1:0] ppu_addr,
    output logic              ppu_ack,
    output logic [DATA_W-1:0] ppu_rdata,
    input  logic              ldr_req,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_ack,
    output logic              mc_read_a,
    output logic              mc_read_b,
    output logic              mc_write,
    output logic              mc_refresh,
    output logic [ADDR_W-1:0] mc_addr,
    output logic [DATA_W-1:0] mc_din,
    input  logic [DATA_W-1:0] mc_dout_a,
    input  logic [DATA_W-1:0] mc_dout_b,
    input  logic              mc_busy,
    output logic [CNT_W-1:0]  refresh_cnt
);

    localparam logic [CNT_W-1:0] URGENT_LVL = CNT_W'(REFRESH_URGENT);

    state_t            r_state;
    owner_t            r_owner;
    logic              r_first_wait;
    logic              r_rr_ppu;
    logic              r_cpu_ack, r_ppu_ack, r_ldr_ack;
    logic [DATA_W-1:0] r_cpu_rdata, r_ppu_rdata;
    logic              r_rd_a, r_rd_b, r_wr, r_ref;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_din;

    logic [CNT_W-1:0]  w_refresh_cnt;
    logic              w_ack_any, w_pick_ppu, w_grant, w_rr_upd;
    owner_t            w_owner;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_din;

    mem_arbiter_refresh_timer #(
        .INTERVAL (REFRESH_INTERVAL),
        .MAX      (REFRESH_MAX)
    ) u_refresh_timer (
        .clk           (clk),
        .resetn        (resetn),
        .i_consume     (r_ref),
        .o_refresh_cnt (w_refresh_cnt)
    );

    // Winner selection. Nothing is granted in an ack cycle so that a request
    // still held while its ack is visible is not mistaken for a new one.
    always_comb begin
        w_ack_any  = r_cpu_ack | r_ppu_ack | r_ldr_ack;
        w_pick_ppu = ppu_req & (~cpu_req | r_rr_ppu);
        w_grant    = 1'b0;
        w_rr_upd   = 1'b0;
        w_owner    = OWN_REF;
        w_addr     = '0;
        w_din      = '0;
        if (!mc_busy && !w_ack_any) begin
            if (w_refresh_cnt >= URGENT_LVL) begin
                w_grant = 1'b1;
            end else if (cpu_req || ppu_req) begin
                w_grant  = 1'b1;
                w_rr_upd = cpu_req & ppu_req;
                if (w_pick_ppu) begin
                    w_owner = OWN_PPU;
                    w_addr  = ppu_addr;
                end else begin
                    w_owner = cpu_we ? OWN_CPU_WR : OWN_CPU_RD;
                    w_addr  = cpu_addr;
                    w_din   = cpu_we ? cpu_wdata : '0;
                end
            end else if (ldr_req) begin
                w_grant = 1'b1;
                w_owner = OWN_LDR;
                w_addr  = ldr_addr;
                w_din   = ldr_wdata;
            end else if (w_refresh_cnt != '0) begin
                w_grant = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_owner      <= OWN_REF;
            r_first_wait <= 1'b0;
            r_rr_ppu     <= 1'b1;
            r_cpu_ack    <= 1'b0;
            r_ppu_ack    <= 1'b0;
            r_ldr_ack    <= 1'b0;
            r_cpu_rdata  <= '0;
            r_ppu_rdata  <= '0;
            r_rd_a       <= 1'b0;
            r_rd_b       <= 1'b0;
            r_wr         <= 1'b0;
            r_ref        <= 1'b0;
            r_addr       <= '0;
            r_din        <= '0;
        end else begin
            r_cpu_ack <= 1'b0;
            r_ppu_ack <= 1'b0;
            r_ldr_ack <= 1'b0;
            r_rd_a    <= 1'b0;
            r_rd_b    <= 1'b0;
            r_wr      <= 1'b0;
            r_ref     <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_owner <= w_owner;
                        r_addr  <= w_addr;
                        r_din   <= w_din;
                        // Pulses are registered here so they are high in ISSUE.
                        r_rd_a  <= (w_owner == OWN_CPU_RD);
                        r_rd_b  <= (w_owner == OWN_PPU);
                        r_wr    <= (w_owner == OWN_CPU_WR) || (w_owner == OWN_LDR);
                        r_ref   <= (w_owner == OWN_REF);
                        // Only a genuine CPU/PPU contest moves the pointer: the loser is favoured next.
                        if (w_rr_upd) r_rr_ppu <= (w_owner != OWN_PPU);
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_first_wait <= 1'b1;
                    r_state      <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_first_wait <= 1'b0;
                    // Controller raises busy one cycle late; skip the first WAIT cycle.
                    if (!r_first_wait && !mc_busy) begin
                        case (r_owner)
                            OWN_CPU_RD: begin
                                r_cpu_ack   <= 1'b1;
                                r_cpu_rdata <= mc_dout_a;
                            end
                            OWN_CPU_WR: r_cpu_ack <= 1'b1;
                            OWN_PPU: begin
                                r_ppu_ack   <= 1'b1;
                                r_ppu_rdata <= mc_dout_b;
                            end
                            OWN_LDR:    r_ldr_ack <= 1'b1;
                            default:    ;
                        endcase
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cpu_ack     = r_cpu_ack;
    assign cpu_rdata   = r_cpu_rdata;
    assign ppu_ack     = r_ppu_ack;
    assign ppu_rdata   = r_ppu_rdata;
    assign ldr_ack     = r_ldr_ack;
    assign mc_read_a   = r_rd_a;
    assign mc_read_b   = r_rd_b;
    assign mc_write    = r_wr;
    assign mc_refresh  = r_ref;
    assign mc_addr     = r_addr;
    assign mc_din      = r_din;
    assign refresh_cnt = w_refresh_cnt;

endmodule
